// File: rtl/s2cif_mon_pkg.sv
// rtl/s2cif_mon_pkg.sv - shared types and sizing helpers for the s2cif output monitor
package s2cif_mon_pkg;

  localparam int ID_W   = 8;
  localparam int SKIP_W = 8;

  typedef enum logic [1:0] {SKIPPING, COLLECT, FLUSH, DONE} state_e;

  function automatic int nbits_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Flattened packet width: data + nbits + last.
  function automatic int pkt_w(input int width);
    return width + nbits_w(width) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_s2cif.sv
// rtl/sync_fifo_s2cif.sv - DEPTH-entry packet FIFO with simultaneous push/pop
module sync_fifo_s2cif #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == FULL_CNT);
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mon_s2cif_pack.sv
// rtl/mon_s2cif_pack.sv - packs qualified DUT dout samples LSB-first into buffered packets
module mon_s2cif_pack
  import s2cif_mon_pkg::*;
#(
  parameter int ID    = 0,
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SKIP  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dout,
  input  logic                         smp_en,
  input  logic                         end_i,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic [WIDTH-1:0]             pkt_data,
  output logic [$clog2(WIDTH+1)-1:0]   pkt_nbits,
  output logic                         pkt_last,
  output logic [ID_W-1:0]              pkt_id,
  output logic                         ovf,
  output logic                         busy
);

  localparam int NBW = nbits_w(WIDTH);
  localparam int PW  = pkt_w(WIDTH);
  localparam logic [NBW-1:0]    FULL_N    = NBW'(WIDTH);
  localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP);
  localparam state_e            START     = (SKIP == 0) ? COLLECT : SKIPPING;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [NBW-1:0]   nbits;
    logic             last;
  } pkt_t;

  state_e            state_q, state_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic [NBW-1:0]    cnt_q, cnt_d, cnt_n;
  logic [WIDTH-1:0]  word_q, word_d, word_n;
  logic              ovf_q, ovf_d;
  pkt_t              push_pkt, head_pkt;
  logic              push, pop, full, empty;

  assign pkt_valid = ~empty;
  assign pop       = pkt_valid & pkt_ready;
  assign pkt_data  = head_pkt.data;
  assign pkt_nbits = head_pkt.nbits;
  assign pkt_last  = head_pkt.last;
  assign pkt_id    = ID_W'(ID);
  assign ovf       = ovf_q;
  assign busy      = (state_q != DONE);

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    ovf_d    = ovf_q;
    push     = 1'b0;
    push_pkt = '0;
    word_n   = word_q;
    cnt_n    = cnt_q;
    case (state_q)
      SKIPPING: begin
        if (end_i) begin
          state_d = FLUSH;
        end else if (smp_en) begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q == SKIP_W'(1)) begin
            state_d = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (smp_en) begin
          word_n[cnt_q] = dout;
          cnt_n         = cnt_q + NBW'(1);
          if (cnt_n == FULL_N) begin
            push     = 1'b1;
            push_pkt = '{data: word_n, nbits: FULL_N, last: 1'b0};
            // No room and nothing leaving: the word is lost, counter restarts anyway.
            if (full && !pop) begin
              ovf_d = 1'b1;
            end
            cnt_n  = '0;
            word_n = '0;
          end
          word_d = word_n;
          cnt_d  = cnt_n;
        end
        if (end_i) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        push     = 1'b1;
        push_pkt = '{data: word_q, nbits: cnt_q, last: 1'b1};
        if (!full || pop) begin
          state_d = DONE;
          word_d  = '0;
          cnt_d   = '0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= START;
      skip_q  <= SKIP_INIT;
      cnt_q   <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo_s2cif #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pop),
    .head      (head_pkt),
    .full      (full),
    .empty     (empty)
  );

endmodule

// File: tb/tb_mon_s2cif_pack.sv
// tb/tb_mon_s2cif_pack.sv - bench for mon_s2cif_pack, SKIP=1 and SKIP=0 instances side by side
module tb_mon_s2cif_pack;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int NBW = $clog2(W + 1);

  typedef logic [12:0] ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic dout = 1'b0, smp_en = 1'b0, end_i = 1'b0, pkt_ready = 1'b0;

  logic           pv   [2];
  logic [W-1:0]   pd   [2];
  logic [NBW-1:0] pn   [2];
  logic           pl   [2];
  logic [7:0]     pid  [2];
  logic           ovf  [2];
  logic           busy [2];

  int passed = 0;
  int total  = 0;

  ent_t q0[$];
  ent_t q1[$];
  int   skip_left [2];
  int   acc       [2];
  int   nb        [2];
  bit   flushing  [2];
  bit   done_m    [2];
  bit   ovf_m     [2];

  always #5 clk = ~clk;

  mon_s2cif_pack #(.ID(3), .WIDTH(W), .DEPTH(D), .SKIP(1)) u0 (
    .clk(clk), .rst(rst), .dout(dout), .smp_en(smp_en), .end_i(end_i),
    .pkt_valid(pv[0]), .pkt_ready(pkt_ready), .pkt_data(pd[0]), .pkt_nbits(pn[0]),
    .pkt_last(pl[0]), .pkt_id(pid[0]), .ovf(ovf[0]), .busy(busy[0]));

  mon_s2cif_pack #(.ID(5), .WIDTH(W), .DEPTH(D), .SKIP(0)) u1 (
    .clk(clk), .rst(rst), .dout(dout), .smp_en(smp_en), .end_i(end_i),
    .pkt_valid(pv[1]), .pkt_ready(pkt_ready), .pkt_data(pd[1]), .pkt_nbits(pn[1]),
    .pkt_last(pl[1]), .pkt_id(pid[1]), .ovf(ovf[1]), .busy(busy[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      skip_left[i] = (i == 0) ? 1 : 0;
      acc[i]       = 0;
      nb[i]        = 0;
      flushing[i]  = 1'b0;
      done_m[i]    = 1'b0;
      ovf_m[i]     = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One clock edge of the stream rules, applied to a packet queue.
  task automatic model_step(input int i, input bit d, input bit en, input bit e, input bit rdy);
    ent_t q[$];
    bit   pop, full;
    if (i == 0) q = q0; else q = q1;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == D);
    if (pop) void'(q.pop_front());
    if (done_m[i]) begin
    end else if (flushing[i]) begin
      if (!full || pop) begin
        q.push_back({1'b1, 4'(nb[i]), 8'(acc[i])});
        done_m[i] = 1'b1;
        acc[i] = 0;
        nb[i] = 0;
      end
    end else if (skip_left[i] > 0) begin
      if (e) flushing[i] = 1'b1;
      else if (en) skip_left[i]--;
    end else begin
      if (en) begin
        acc[i] = acc[i] + (int'(d) << nb[i]);
        nb[i]++;
        if (nb[i] == W) begin
          if (!full || pop) q.push_back({1'b0, 4'(W), 8'(acc[i])});
          else ovf_m[i] = 1'b1;
          acc[i] = 0;
          nb[i] = 0;
        end
      end
      if (e) flushing[i] = 1'b1;
    end
    if (i == 0) q0 = q; else q1 = q;
  endtask

  function automatic logic [15:0] obs_vec(input int i);
    return {pv[i], pl[i], pn[i], pd[i], ovf[i], busy[i]};
  endfunction

  function automatic logic [15:0] exp_vec(input int i);
    ent_t h;
    int   sz;
    if (i == 0) begin
      sz = q0.size();
      h  = (sz > 0) ? q0[0] : '0;
    end else begin
      sz = q1.size();
      h  = (sz > 0) ? q1[0] : '0;
    end
    return {sz > 0, h[12], h[11:8], h[7:0], ovf_m[i], !done_m[i]};
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < 2; i++) check($sformatf("%s.u%0d", tag, i), obs_vec(i), exp_vec(i));
  endtask

  task automatic step(input bit d, input bit en, input bit e, input bit rdy, input string tag);
    dout = d; smp_en = en; end_i = e; pkt_ready = rdy;
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i, d, en, e, rdy);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic apply_reset();
    dout = 1'b0; smp_en = 1'b0; end_i = 1'b0; pkt_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b1;
    check_all("rst_rel");
  endtask

  initial begin
    logic [8:0] pat1;
    pat1 = 9'b111001011;

    model_reset();
    @(negedge clk);
    check_all("reset");
    check("id0", pid[0], 8'd3);
    check("id1", pid[1], 8'd5);
    rst = 1'b1;

    // Basic packing: SKIP=1 drops the first sample, SKIP=0 keeps it.
    for (int k = 0; k < 9; k++) begin
      step(pat1[k], 1'b1, 1'b0, 1'b1, "pack");
      if (k == 7) check("u1_word_cb", {pl[1], pn[1], pd[1]}, 13'h08CB);
      if (k == 8) check("u0_word_e5", {pl[0], pn[0], pd[0]}, 13'h08E5);
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, "tail");
    step(1'b0, 1'b1, 1'b0, 1'b1, "tail");
    step(1'b1, 1'b1, 1'b0, 1'b1, "tail");
    step(1'b0, 1'b0, 1'b1, 1'b1, "end");
    step(1'b0, 1'b0, 1'b0, 1'b1, "flush");
    check("u0_last", {pl[0], pn[0], pd[0]}, 13'h1305);
    check("u1_last", {pl[1], pn[1], pd[1]}, 13'h140B);
    step(1'b0, 1'b0, 1'b0, 1'b1, "drain");
    check("done_busy", {busy[0], busy[1], pv[0], pv[1]}, 4'b0000);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'(k == 3), 1'b1, "done_ign");

    // Word completion and end_i on the same edge.
    apply_reset();
    for (int k = 0; k < 8; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'(k == 7), 1'b1, "coinc");
    check("u1_coinc_full", {pl[1], pn[1]}, 5'b0_1000);
    step(1'b0, 1'b0, 1'b0, 1'b1, "coinc_last");
    check("u1_coinc_empty", {pl[1], pn[1], pd[1]}, 13'h1000);
    step(1'b0, 1'b0, 1'b0, 1'b1, "coinc_drain");

    // Overflow, stalled flush, then ordered drain.
    apply_reset();
    for (int k = 0; k < 41; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, "fill");
    check("ovf_set", {ovf[0], ovf[1]}, 2'b11);
    step(1'b0, 1'b0, 1'b1, 1'b0, "ovf_end");
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b0, "stall");
    check("stall_busy", {busy[0], busy[1]}, 2'b11);
    for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "ovf_drain");
    check("drained", {pv[0], pv[1], busy[0], busy[1]}, 4'b0000);

    // Full FIFO: pop and word completion on the same edge.
    apply_reset();
    for (int k = 0; k < 40; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, "full");
    step(1'b1, 1'b1, 1'b0, 1'b1, "full_pop");
    check("pop_push_ovf", {ovf[0], ovf[1]}, 2'b01);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'b0, 1'b1, "full_drain");

    // Asynchronous reset mid-word with packets queued.
    apply_reset();
    for (int k = 0; k < 20; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, "pre_rst");
    check("queued", {pv[0], pv[1]}, 2'b11);
    apply_reset();
    check("rst_clear", {pv[0], pv[1], ovf[0], ovf[1]}, 4'b0000);
    for (int k = 0; k < 9; k++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b0, "fresh");
    check("fresh_u0", {pv[0], pl[0], pn[0]}, 6'b10_1000);

    // Randomized traffic against the reference model.
    apply_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0 || (done_m[0] && done_m[1] && $urandom_range(0, 9) == 0))
        apply_reset();
      else
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
